mod3_frame_tx: RTL and testbench
================================

Name: mod3_frame_tx

Overview:
- Serial transmitter for the mod-3 checker path.
- Accepts a W-bit parallel word, shifts it out MSB-first on a single-bit line, then appends a 2-bit check field.
- The check field makes the whole (W+2)-bit frame an exact multiple of 3. A mod-3 serial checker fed from this block therefore reports divisible on the last frame bit.
- Sits in front of the serial mod-3 checker as its stimulus/encoder end.

Parameters:
- W, 8, data word width in bits (W >= 1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request to send; sampled only when ready=1.
- data  input  W  word to send; captured on the accepting edge.
- ready  output  1  block can accept start this cycle.
- sout  output  1  serial bit, MSB first.
- sout_valid  output  1  sout carries a frame bit this cycle.
- sof  output  1  high with the first bit (data[W-1]) of each frame.
- last  output  1  high with the final check bit of each frame.

Behaviour:
- Reset (rst=0, async): state=IDLE, shift reg=0, residue r=0, bit counter=0, sout=0, sout_valid=0, sof=0, last=0. ready=1 while in reset/IDLE.
- States:
  - IDLE: sout_valid=0.
  - DATA: W cycles.
  - CHK1: emit check bit 1.
  - CHK0: emit check bit 0.
- ready = (state==IDLE) or (state==CHK0). It is decoded from state; all other outputs are registered.
- Accept: rising edge with ready=1 and start=1.
  - Latches data.
  - Clears r.
  - Next state = DATA.
- Latency: first bit appears on sout in the cycle after the accepting edge.
- DATA:
  - sout = current MSB of the shift register; sout_valid=1.
  - sof=1 only in the first DATA cycle.
  - Each edge updates r <= (2r + sout) mod 3, shifts left, and increments the counter.
  - After W bits, goes to CHK1.
- Check value: c = (3 - r) mod 3, using r after all W data bits (c in {0,1,2}).
  - CHK1 emits c[1]; CHK0 emits c[0].
  - last=1 only in CHK0.
  - Arithmetic: frame value = 4*data + c ≡ data + c ≡ 0 (mod 3).
- Frame length: exactly W+2 consecutive sout_valid cycles, no gaps.
- Leaving CHK0:
  - With start=1, accept the new word and go directly to DATA. The next frame's sof follows the previous last with no idle cycle (back-to-back).
  - Otherwise go to IDLE with sout_valid=0 and sout=0.
- start while ready=0: ignored and not queued; data changes mid-frame have no effect.
- W=1: DATA lasts one cycle and carries both sof and the only data bit; the frame is 3 bits.
- Reset mid-frame: outputs drop to reset values immediately (async). No partial check bits are emitted. The first post-reset frame starts clean with r=0.
- In IDLE, sout is held 0; sof and last never assert without sout_valid.

Test Plan:
- W=8, data=8'd5, one start pulse -> sout over 10 cycles = 0,0,0,0,0,1,0,1,0,1 (frame=21). sof on cycle 1, last on cycle 10, ready=0 during cycles 1-9.
- data=8'd7 -> check bits 1,0 (frame=30); data=8'd6 -> check 0,0 (frame=24); data=8'hFF -> check 0,0 (frame=1020).
- Back-to-back: start held high with 8'd5 then 8'd7 -> 20 contiguous sout_valid cycles, sof at cycles 1 and 11, last at 10 and 20. Chain into the mod-3 checker: its output is 1 on cycles 10 and 20.
- start pulsed, and data changed, during cycle 4 of a frame -> ignored; the frame completes with the original data and check bits.
- rst=0 asserted asynchronously in cycle 5 of a frame -> sout_valid, sof, last and sout go 0 before the next edge, ready=1. After release, new start with 8'd5 produces the exact sequence of scenario 1.
- W=1 instance: data=1 -> sout 1,1,0 (frame=6) with sof and last on cycles 1 and 3; data=0 -> 0,0,0.

Source files
------------

// File: rtl/mod3_frame_tx.sv
// Serial mod-3 frame transmitter.
// Sends a W-bit word MSB-first, then two check bits that make the whole frame a multiple of 3.
module mod3_frame_tx #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] data,
    output logic         ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         sof,
    output logic         last,
    output logic [1:0]   dbg_state
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, DATA, CHK1, CHK0} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [1:0]    r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sout_q, sout_d;
    logic          valid_q, valid_d;
    logic          sof_q, sof_d;
    logic          last_q, last_d;
    logic          accept;
    logic [1:0]    c;

    // Residue of (2r + b) mod 3 for r in {0,1,2}.
    function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
        case ({r, b})
            3'b001:  mod3_step = 2'd1;
            3'b010:  mod3_step = 2'd2;
            3'b100:  mod3_step = 2'd1;
            3'b101:  mod3_step = 2'd2;
            default: mod3_step = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] chk_of(input logic [1:0] r);
        case (r)
            2'd1:    chk_of = 2'd2;
            2'd2:    chk_of = 2'd1;
            default: chk_of = 2'd0;
        endcase
    endfunction

    assign ready  = (state_q == IDLE) || (state_q == CHK0);
    assign accept = ready && start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            r_q     <= 2'd0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DATA;
            DATA:    if (cnt_q == LAST_CNT) state_d = CHK1;
            CHK1:    state_d = CHK0;
            CHK0:    state_d = start ? DATA : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output bits are computed one edge ahead so every output leaves a flop.
    always_comb begin
        shift_d = shift_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        sout_d  = 1'b0;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        last_d  = 1'b0;
        c       = 2'd0;
        if (accept) begin
            shift_d = data;
            r_d     = 2'd0;
            cnt_d   = '0;
            sout_d  = data[W-1];
            valid_d = 1'b1;
            sof_d   = 1'b1;
        end else begin
            case (state_q)
                DATA: begin
                    r_d     = mod3_step(r_q, shift_q[W-1]);
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q + 1'b1;
                    valid_d = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        c      = chk_of(r_d);
                        sout_d = c[1];
                    end else begin
                        sout_d = shift_d[W-1];
                    end
                end
                CHK1: begin
                    c       = chk_of(r_q);
                    sout_d  = c[0];
                    valid_d = 1'b1;
                    last_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sout       = sout_q;
    assign sout_valid = valid_q;
    assign sof        = sof_q;
    assign last       = last_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mod3_frame_tx.sv
// Bench for mod3_frame_tx: W=8 and W=1 instances share clock, reset and start.
// Each instance is checked every cycle against a frame-level model built from 4*data + c.
module tb_mod3_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data8 = 8'd0;
  logic [0:0] data1;

  logic       ready8, sout8, valid8, sof8, last8;
  logic       ready1, sout1, valid1, sof1, last1;
  logic [1:0] dbg8, dbg1;

  int checks = 0;
  int failures = 0;

  // {sout, sof, last} for every frame bit still to appear
  logic [2:0] exp8_q[$];
  logic [2:0] exp1_q[$];

  logic [9:0] cap8, frame8;
  logic [2:0] cap1, frame1;
  int         res8, res1, run8, last_run8;

  assign data1 = data8[0];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mod3_frame_tx #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .data(data8),
    .ready(ready8), .sout(sout8), .sout_valid(valid8), .sof(sof8), .last(last8),
    .dbg_state(dbg8)
  );

  mod3_frame_tx #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .data(data1),
    .ready(ready1), .sout(sout1), .sout_valid(valid1), .sof(sof1), .last(last1),
    .dbg_state(dbg1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame value = 4*data + c, with c chosen so the frame is divisible by 3.
  function automatic int frame_value(input int d);
    return 4 * d + (3 - (d % 3)) % 3;
  endfunction

  task automatic push_frame8(input int d);
    int f;
    f = frame_value(d);
    for (int i = 9; i >= 0; i--)
      exp8_q.push_back({f[i], (i == 9), (i == 0)});
  endtask

  task automatic push_frame1(input int d);
    int f;
    f = frame_value(d);
    for (int i = 2; i >= 0; i--)
      exp1_q.push_back({f[i], (i == 2), (i == 0)});
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [2:0] e;
    logic       er;
    if (!rst) begin
      exp8_q.delete();
      exp1_q.delete();
      chk("rst8_valid", valid8, 0);
      chk("rst8_sout", sout8, 0);
      chk("rst8_ready", ready8, 1);
      chk("rst1_valid", valid1, 0);
      chk("rst1_ready", ready1, 1);
      run8 = 0;
    end else begin
      if (exp8_q.size() > 0) begin
        e = exp8_q.pop_front();
        chk("w8_valid", valid8, 1);
        chk("w8_sout", sout8, e[2]);
        chk("w8_sof", sof8, e[1]);
        chk("w8_last", last8, e[0]);
        er = e[0];
      end else begin
        chk("w8_idle_valid", valid8, 0);
        chk("w8_idle_sout", sout8, 0);
        chk("w8_idle_sof", sof8, 0);
        chk("w8_idle_last", last8, 0);
        er = 1'b1;
      end
      chk("w8_ready", ready8, er);
      if (er && start) push_frame8(data8);

      if (exp1_q.size() > 0) begin
        e = exp1_q.pop_front();
        chk("w1_valid", valid1, 1);
        chk("w1_sout", sout1, e[2]);
        chk("w1_sof", sof1, e[1]);
        chk("w1_last", last1, e[0]);
        er = e[0];
      end else begin
        chk("w1_idle_valid", valid1, 0);
        chk("w1_idle_sout", sout1, 0);
        er = 1'b1;
      end
      chk("w1_ready", ready1, er);
      if (er && start) push_frame1(data1);

      // Capture frames and run a serial mod-3 check on what the DUT emits.
      if (valid8) begin
        cap8 = sof8 ? {9'd0, sout8} : {cap8[8:0], sout8};
        res8 = sof8 ? int'(sout8) : (2 * res8 + int'(sout8)) % 3;
        run8++;
        if (last8) begin
          frame8 = cap8;
          chk("w8_mod3_on_last", res8, 0);
        end
      end else begin
        if (run8 > 0) last_run8 = run8;
        run8 = 0;
      end
      if (valid1) begin
        cap1 = sof1 ? {2'd0, sout1} : {cap1[1:0], sout1};
        res1 = sof1 ? int'(sout1) : (2 * res1 + int'(sout1)) % 3;
        if (last1) begin
          frame1 = cap1;
          chk("w1_mod3_on_last", res1, 0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic s, input logic [7:0] d);
    @(posedge clk);
    #2;
    start = s;
    data8 = d;
  endtask

  task automatic send_one(input logic [7:0] d);
    cyc(1'b1, d);
    repeat (13) cyc(1'b0, d);
  endtask

  initial begin
    frame8 = '0; frame1 = '0; cap8 = '0; cap1 = '0;
    res8 = 0; res1 = 0; run8 = 0; last_run8 = 0;
    #1;
    chk("reset_ready8", ready8, 1);
    chk("reset_valid8", valid8, 0);
    chk("reset_sof8", sof8, 0);
    chk("reset_last8", last8, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) cyc(1'b0, 8'd0);

    send_one(8'd5);
    chk("frame_5", frame8, 21);
    chk("w1_frame_1", frame1, 6);
    chk("frame_5_len", last_run8, 10);
    send_one(8'd7);
    chk("frame_7", frame8, 30);
    send_one(8'd6);
    chk("frame_6", frame8, 24);
    chk("w1_frame_0", frame1, 0);
    send_one(8'hFF);
    chk("frame_ff", frame8, 1020);

    // Back-to-back: start held, 5 then 7 sampled at the two accepting edges.
    cyc(1'b1, 8'd5);
    repeat (9) cyc(1'b1, 8'd5);
    cyc(1'b1, 8'd7);
    repeat (12) cyc(1'b0, 8'd0);
    chk("b2b_second_frame", frame8, 30);
    chk("b2b_run_len", last_run8, 20);

    // start and data change mid-frame are ignored.
    cyc(1'b1, 8'd5);
    repeat (3) cyc(1'b0, 8'd5);
    cyc(1'b1, 8'hAA);
    repeat (13) cyc(1'b0, 8'hAA);
    chk("midframe_ignored", frame8, 21);

    // Asynchronous reset in the middle of a frame.
    cyc(1'b1, 8'd5);
    repeat (4) cyc(1'b0, 8'd5);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", valid8, 0);
    chk("async_sout", sout8, 0);
    chk("async_sof", sof8, 0);
    chk("async_last", last8, 0);
    chk("async_ready", ready8, 1);
    chk("async_frame_unchanged", frame8, 21);
    @(posedge clk);
    #2 rst = 1'b1;
    send_one(8'd5);
    chk("post_reset_frame", frame8, 21);
    chk("post_reset_len", last_run8, 10);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 150) == 0) begin
        rst = 1'b0;
        cyc(1'b0, 8'd0);
        rst = 1'b1;
      end
    end
    repeat (14) cyc(1'b0, 8'd0);
    chk("drain8_empty", exp8_q.size(), 0);
    chk("drain1_empty", exp1_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
